// File: rtl/hamming_encoder_serial.sv
// Serial (15,11) Hamming encoder: collects 11 data bits (d0 first), emits the
// 15-bit even-parity codeword serially, Hamming position 1 first.
//
// state | meaning
// IDLE  | no codeword in flight, waiting for a held word
// SHIFT | driving codeword bit out_cnt on s_out
// GAP   | inter-frame idle, GAP_CYCLES cycles long
module hamming_encoder_serial #(
  parameter int unsigned GAP_CYCLES = 0,
  parameter bit          OUT_IDLE   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic s_in,
  input  logic s_in_valid,
  output logic s_in_ready,
  output logic s_out,
  output logic s_out_valid,
  output logic s_out_sof
);

  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP_LAST);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [9:0]       col_sr;
  logic [3:0]       col_cnt;
  logic [10:0]      hold_word;
  logic             hold_full;
  logic             accept;
  logic             word_done;
  logic [10:0]      word_new;
  logic             load;
  logic [14:0]      cw;
  logic [13:0]      out_sr;
  logic [3:0]       out_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic             p1, p2, p4, p8;

  // Only the 11th bit of a word stalls while the hold buffer is occupied.
  assign s_in_ready = (col_cnt != 4'd10) || !hold_full;
  assign accept     = s_in_valid && s_in_ready;
  assign word_done  = accept && (col_cnt == 4'd10);
  assign word_new   = {s_in, col_sr};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col_sr    <= '0;
      col_cnt   <= '0;
      hold_word <= '0;
      hold_full <= 1'b0;
    end else begin
      if (accept) begin
        col_sr  <= {s_in, col_sr[9:1]};
        col_cnt <= word_done ? 4'd0 : col_cnt + 4'd1;
      end
      if (word_done) hold_word <= word_new;
      // A load on the same edge as a new word still leaves the buffer full.
      if (word_done)  hold_full <= 1'b1;
      else if (load)  hold_full <= 1'b0;
    end
  end

  assign p1 = hold_word[0] ^ hold_word[1] ^ hold_word[3] ^ hold_word[4] ^
              hold_word[6] ^ hold_word[8] ^ hold_word[10];
  assign p2 = hold_word[0] ^ hold_word[2] ^ hold_word[3] ^ hold_word[5] ^
              hold_word[6] ^ hold_word[9] ^ hold_word[10];
  assign p4 = hold_word[1] ^ hold_word[2] ^ hold_word[3] ^ hold_word[7] ^
              hold_word[8] ^ hold_word[9] ^ hold_word[10];
  assign p8 = hold_word[4] ^ hold_word[5] ^ hold_word[6] ^ hold_word[7] ^
              hold_word[8] ^ hold_word[9] ^ hold_word[10];

  assign cw = {hold_word[10:4], p8, hold_word[3:1], p4, hold_word[0], p2, p1};

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          load     = 1'b1;
          state_nx = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (out_cnt == 4'd14) begin
          if (GAP_CYCLES > 0) begin
            state_nx = ST_GAP;
          end else if (hold_full) begin
            load = 1'b1;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        // Leaving the gap straight into SHIFT keeps the idle span at exactly GAP_CYCLES.
        if (gap_cnt == '0) begin
          if (hold_full) begin
            load     = 1'b1;
            state_nx = ST_SHIFT;
          end else begin
            state_nx = ST_IDLE;
          end
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      out_sr      <= '0;
      out_cnt     <= '0;
      gap_cnt     <= '0;
      s_out       <= OUT_IDLE;
      s_out_valid <= 1'b0;
      s_out_sof   <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        out_sr  <= cw[14:1];
        out_cnt <= '0;
      end else if (state == ST_SHIFT) begin
        out_sr <= {1'b0, out_sr[13:1]};
        if (out_cnt != 4'd14) out_cnt <= out_cnt + 4'd1;
      end
      if (state_nx == ST_GAP && state != ST_GAP) begin
        gap_cnt <= GAP_INIT;
      end else if (state == ST_GAP && gap_cnt != '0) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
      s_out_valid <= (state_nx == ST_SHIFT);
      s_out_sof   <= load;
      if (load)                        s_out <= cw[0];
      else if (state_nx == ST_SHIFT)   s_out <= out_sr[0];
      else                             s_out <= OUT_IDLE;
    end
  end

endmodule

// File: tb/tb_hamming_encoder_serial.sv
// Bench for hamming_encoder_serial: two instances (back-to-back and gapped
// framing) checked against a position-based Hamming reference model.
module tb_hamming_encoder_serial;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, a_in, a_vld, a_rdy, a_out, a_ovld, a_sof;
  logic rst_b, b_in, b_vld, b_rdy, b_out, b_ovld, b_sof;

  hamming_encoder_serial #(.GAP_CYCLES(0), .OUT_IDLE(1'b0)) dut_a (
    .clk(clk), .reset(rst_a), .s_in(a_in), .s_in_valid(a_vld), .s_in_ready(a_rdy),
    .s_out(a_out), .s_out_valid(a_ovld), .s_out_sof(a_sof)
  );

  hamming_encoder_serial #(.GAP_CYCLES(3), .OUT_IDLE(1'b1)) dut_b (
    .clk(clk), .reset(rst_b), .s_in(b_in), .s_in_valid(b_vld), .s_in_ready(b_rdy),
    .s_out(b_out), .s_out_valid(b_ovld), .s_out_sof(b_sof)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Data fills the non-power-of-two positions in order; parity p covers every
  // position whose index has bit p set.
  function automatic logic [14:0] ref_encode(input logic [10:0] d);
    logic [14:0] c;
    int k;
    logic x;
    c = '0;
    k = 0;
    for (int p = 1; p <= 15; p++) begin
      if ((p & (p - 1)) != 0) begin
        c[p-1] = d[k];
        k++;
      end
    end
    for (int p = 1; p <= 8; p = p * 2) begin
      x = 1'b0;
      for (int q = 1; q <= 15; q++)
        if (((q & p) != 0) && (q != p)) x = x ^ c[q-1];
      c[p-1] = x;
    end
    return c;
  endfunction

  function automatic logic [10:0] ref_decode(input logic [14:0] cw);
    logic [14:0] c;
    logic [10:0] d;
    int syn;
    int k;
    c = cw;
    d = '0;
    syn = 0;
    k = 0;
    for (int q = 1; q <= 15; q++) if (c[q-1]) syn = syn ^ q;
    if (syn != 0) c[syn-1] = ~c[syn-1];
    for (int q = 1; q <= 15; q++) begin
      if ((q & (q - 1)) != 0) begin
        d[k] = c[q-1];
        k++;
      end
    end
    return d;
  endfunction

  logic [10:0] a_exp[$];
  logic [10:0] b_exp[$];
  int          b_gaps[$];
  logic [14:0] a_cur, a_last, b_cur;
  logic [10:0] a_w, b_w;
  int a_idx = 0, a_nframes = 0, a_run = 0, a_run_max = 0;
  int b_idx = 0, b_nframes = 0, b_gap = 0;

  always @(negedge clk) begin
    if (!rst_a) begin
      a_idx = 0;
      a_run = 0;
    end else if (a_ovld) begin
      check("a_sof", a_sof, a_idx == 0);
      a_cur[a_idx] = a_out;
      a_idx++;
      a_run++;
      if (a_run > a_run_max) a_run_max = a_run;
      if (a_idx == 15) begin
        a_idx = 0;
        a_nframes++;
        a_last = a_cur;
        check("a_exp_avail", a_exp.size() != 0, 1);
        if (a_exp.size() != 0) begin
          a_w = a_exp.pop_front();
          check("a_cw_model", a_cur, ref_encode(a_w));
          check("a_cw_decode", ref_decode(a_cur), a_w);
        end
      end
    end else begin
      check("a_idle_lvl", a_out, 0);
      check("a_idle_sof", a_sof, 0);
      check("a_split", a_idx, 0);
      a_run = 0;
    end
  end

  always @(negedge clk) begin
    if (!rst_b) begin
      b_idx = 0;
      b_gap = 0;
    end else if (b_ovld) begin
      check("b_sof", b_sof, b_idx == 0);
      if (b_idx == 0 && b_nframes > 0) b_gaps.push_back(b_gap);
      b_gap = 0;
      b_cur[b_idx] = b_out;
      b_idx++;
      if (b_idx == 15) begin
        b_idx = 0;
        b_nframes++;
        check("b_exp_avail", b_exp.size() != 0, 1);
        if (b_exp.size() != 0) begin
          b_w = b_exp.pop_front();
          check("b_cw_model", b_cur, ref_encode(b_w));
          check("b_cw_decode", ref_decode(b_cur), b_w);
        end
      end
    end else begin
      check("b_idle_lvl", b_out, 1);
      check("b_split", b_idx, 0);
      b_gap++;
    end
  end

  // Called at a negedge; returns at the negedge after the bit is accepted.
  task automatic drive_bit_a(input logic v, input int i);
    int g;
    g = 0;
    a_in  = v;
    a_vld = 1'b1;
    while (!a_rdy && g < 64) begin
      check("a_stall_bit", i, 10);
      @(negedge clk);
      g++;
    end
    if (g >= 64) check("a_rdy_timeout", g, 0);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_a(input logic [10:0] w);
    a_exp.push_back(w);
    for (int i = 0; i < 11; i++) drive_bit_a(w[i], i);
  endtask

  task automatic send_b(input logic [10:0] w);
    int g;
    b_exp.push_back(w);
    for (int i = 0; i < 11; i++) begin
      g = 0;
      b_in  = w[i];
      b_vld = 1'b1;
      while (!b_rdy && g < 64) begin
        check("b_stall_bit", i, 10);
        @(negedge clk);
        g++;
      end
      if (g >= 64) check("b_rdy_timeout", g, 0);
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic wait_a(input int n);
    int g;
    g = 0;
    while (a_nframes < n && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("a_frames_seen", a_nframes >= n, 1);
  endtask

  task automatic wait_b(input int n);
    int g;
    g = 0;
    while (b_nframes < n && g < 600) begin
      @(negedge clk);
      g++;
    end
    check("b_frames_seen", b_nframes >= n, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, g;
    logic [10:0] w5, fresh;
    rst_a = 1'b0; rst_b = 1'b0;
    a_in = 1'b0; a_vld = 1'b0; b_in = 1'b0; b_vld = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_a_out", a_out, 0);
    check("rst_a_vld", a_ovld, 0);
    check("rst_a_sof", a_sof, 0);
    check("rst_a_rdy", a_rdy, 1);
    check("rst_b_out", b_out, 1);
    check("rst_b_rdy", b_rdy, 1);
    rst_a = 1'b1; rst_b = 1'b1;
    @(negedge clk);

    send_a(11'h000); a_vld = 1'b0;
    wait_a(1);
    check("cw_000", a_last, 15'h0000);
    repeat (3) @(negedge clk);

    send_a(11'h001); a_vld = 1'b0;
    check("lat_pre_vld", a_ovld, 0);
    @(negedge clk);
    check("lat_vld", a_ovld, 1);
    check("lat_sof", a_sof, 1);
    check("lat_bit0", a_out, 1);
    wait_a(2);
    check("cw_001", a_last, 15'h0007);
    repeat (3) @(negedge clk);

    send_a(11'h400); a_vld = 1'b0;
    wait_a(3);
    check("cw_400", a_last, 15'h408B);
    repeat (3) @(negedge clk);
    send_a(11'h7FF); a_vld = 1'b0;
    wait_a(4);
    check("cw_7ff", a_last, 15'h7FFF);
    repeat (5) @(negedge clk);

    for (int k = 0; k < 4; k++) send_a(11'($urandom_range(0, 2047)));
    a_vld = 1'b0;
    wait_a(8);
    check("stream_run", a_run_max, 60);
    repeat (5) @(negedge clk);

    base = a_nframes;
    w5 = 11'($urandom_range(0, 2047));
    fork
      begin
        for (int k = 0; k < 4; k++) send_a(11'($urandom_range(0, 2047)));
        for (int i = 0; i < 5; i++) drive_bit_a(w5[i], i);
        a_vld = 1'b0;
      end
      begin
        g = 0;
        while (!(a_nframes == base + 2 && a_idx == 7) && g < 500) begin
          @(negedge clk);
          g++;
        end
        check("rst_trigger", g < 500, 1);
        check("pre_rst_vld", a_ovld, 1);
        rst_a = 1'b0;
        #1;
        check("mid_rst_out", a_out, 0);
        check("mid_rst_vld", a_ovld, 0);
        check("mid_rst_sof", a_sof, 0);
        check("mid_rst_rdy", a_rdy, 1);
        repeat (12) @(negedge clk);
      end
    join
    a_exp.delete();
    a_vld = 1'b0;
    rst_a = 1'b1;
    @(negedge clk);
    check("post_rst_vld", a_ovld, 0);
    fresh = 11'($urandom_range(0, 2047));
    send_a(fresh); a_vld = 1'b0;
    wait_a(base + 3);
    check("post_rst_cw", a_last, ref_encode(fresh));
    repeat (40) @(negedge clk);
    check("no_residue", a_nframes, base + 3);

    for (int k = 0; k < 5; k++) send_b(11'($urandom_range(0, 2047)));
    b_vld = 1'b0;
    wait_b(5);
    check("b_gap_count", b_gaps.size(), 4);
    foreach (b_gaps[i]) check("b_gap_len", b_gaps[i], 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
